// File: rtl/cdb_arbiter.sv
// Two-source common data bus arbiter: one holding slot per producer, round-robin grant, registered broadcast.
// Optional macro CDB_ARB_BYPASS_EN lets an accepted request into an empty slot compete in the same cycle.
module cdb_arbiter #(
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                valid_from_alu,
  input  logic [ROB_ID_W-1:0] rob_id_from_alu,
  input  logic [DATA_W-1:0]   result_from_alu,
  output logic                ready_to_alu,
  input  logic                valid_from_lsb,
  input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
  input  logic [DATA_W-1:0]   result_from_lsb,
  output logic                ready_to_lsb,
  input  logic                commit_jump_flag_from_rob,
  output logic                valid_to_cdb,
  output logic [ROB_ID_W-1:0] rob_id_to_cdb,
  output logic [DATA_W-1:0]   result_to_cdb
);

  logic                alu_full;
  logic [ROB_ID_W-1:0] alu_tag;
  logic [DATA_W-1:0]   alu_data;
  logic                lsb_full;
  logic [ROB_ID_W-1:0] lsb_tag;
  logic [DATA_W-1:0]   lsb_data;
  logic                prio;

  logic                alu_inc;
  logic                lsb_inc;
  logic                cand_alu;
  logic                cand_lsb;
  logic                grant_alu;
  logic                grant_lsb;
  logic                accept_alu;
  logic                accept_lsb;
  logic                write_alu;
  logic                write_lsb;
  logic [ROB_ID_W-1:0] win_tag;
  logic [DATA_W-1:0]   win_data;

  // A request carrying the reserved zero tag handshakes but is never stored or broadcast.
  always_comb begin
    alu_inc = valid_from_alu & (rob_id_from_alu != '0);
    lsb_inc = valid_from_lsb & (rob_id_from_lsb != '0);
`ifdef CDB_ARB_BYPASS_EN
    cand_alu = alu_full | (rdy & alu_inc);
    cand_lsb = lsb_full | (rdy & lsb_inc);
`else
    cand_alu = alu_full;
    cand_lsb = lsb_full;
`endif
    grant_alu = rdy & cand_alu & (~cand_lsb | ~prio);
    grant_lsb = rdy & cand_lsb & (~cand_alu | prio);
    ready_to_alu = rdy & (~alu_full | grant_alu);
    ready_to_lsb = rdy & (~lsb_full | grant_lsb);
    accept_alu = alu_inc & ready_to_alu;
    accept_lsb = lsb_inc & ready_to_lsb;
    // A bypassed winner (granted while its slot is empty) skips the slot entirely.
    write_alu = accept_alu & ~(grant_alu & ~alu_full);
    write_lsb = accept_lsb & ~(grant_lsb & ~lsb_full);
    win_tag  = '0;
    win_data = '0;
    if (grant_alu) begin
      win_tag  = alu_full ? alu_tag  : rob_id_from_alu;
      win_data = alu_full ? alu_data : result_from_alu;
    end else if (grant_lsb) begin
      win_tag  = lsb_full ? lsb_tag  : rob_id_from_lsb;
      win_data = lsb_full ? lsb_data : result_from_lsb;
    end
  end

  // A mispredict flush behaves exactly like reset and overrides a stalled rdy.
  always_ff @(posedge clk) begin
    if (rst || commit_jump_flag_from_rob) begin
      alu_full      <= 1'b0;
      alu_tag       <= '0;
      alu_data      <= '0;
      lsb_full      <= 1'b0;
      lsb_tag       <= '0;
      lsb_data      <= '0;
      prio          <= 1'b0;
      valid_to_cdb  <= 1'b0;
      rob_id_to_cdb <= '0;
      result_to_cdb <= '0;
    end else if (rdy) begin
      if (write_alu) begin
        alu_full <= 1'b1;
        alu_tag  <= rob_id_from_alu;
        alu_data <= result_from_alu;
      end else if (grant_alu) begin
        alu_full <= 1'b0;
      end
      if (write_lsb) begin
        lsb_full <= 1'b1;
        lsb_tag  <= rob_id_from_lsb;
        lsb_data <= result_from_lsb;
      end else if (grant_lsb) begin
        lsb_full <= 1'b0;
      end
      if (grant_alu || grant_lsb) begin
        valid_to_cdb  <= 1'b1;
        rob_id_to_cdb <= win_tag;
        result_to_cdb <= win_data;
        prio          <= grant_alu;
      end else begin
        valid_to_cdb <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, single request, flush, contention, stall, zero tag.
module tb_cdb_arbiter;

  localparam int ROB_ID_W = 4;
  localparam int DATA_W   = 32;

  logic                clk;
  logic                rst;
  logic                rdy;
  logic                valid_from_alu;
  logic [ROB_ID_W-1:0] rob_id_from_alu;
  logic [DATA_W-1:0]   result_from_alu;
  logic                ready_to_alu;
  logic                valid_from_lsb;
  logic [ROB_ID_W-1:0] rob_id_from_lsb;
  logic [DATA_W-1:0]   result_from_lsb;
  logic                ready_to_lsb;
  logic                commit_jump_flag_from_rob;
  logic                valid_to_cdb;
  logic [ROB_ID_W-1:0] rob_id_to_cdb;
  logic [DATA_W-1:0]   result_to_cdb;

  int compared   = 0;
  int mismatched = 0;

  // Contention stimulus per edge and the bus contents expected right after that edge.
  logic       c_av [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] c_at [8] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
  logic       c_lv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] c_lt [8] = '{4'd5, 4'd6, 4'd6, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0};
  logic       c_ra [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       c_rl [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       c_ev [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] c_et [8] = '{4'd0, 4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd7};
  logic [31:0] c_ed [8] = '{32'h0, 32'hA000_0001, 32'hB000_0005, 32'hA000_0002,
                            32'hB000_0006, 32'hA000_0003, 32'hB000_0007, 32'hB000_0007};

  cdb_arbiter #(.ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .rdy                       (rdy),
    .valid_from_alu            (valid_from_alu),
    .rob_id_from_alu           (rob_id_from_alu),
    .result_from_alu           (result_from_alu),
    .ready_to_alu              (ready_to_alu),
    .valid_from_lsb            (valid_from_lsb),
    .rob_id_from_lsb           (rob_id_from_lsb),
    .result_from_lsb           (result_from_lsb),
    .ready_to_lsb              (ready_to_lsb),
    .commit_jump_flag_from_rob (commit_jump_flag_from_rob),
    .valid_to_cdb              (valid_to_cdb),
    .rob_id_to_cdb             (rob_id_to_cdb),
    .result_to_cdb             (result_to_cdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [3:0] at, input logic [31:0] ad,
                               input logic lv, input logic [3:0] lt, input logic [31:0] ld);
    valid_from_alu  = av;
    rob_id_from_alu = at;
    result_from_alu = ad;
    valid_from_lsb  = lv;
    rob_id_from_lsb = lt;
    result_from_lsb = ld;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBus(input string tag, input logic v, input logic [3:0] t, input logic [31:0] d);
    checkOutput({tag, "_valid"}, {31'b0, valid_to_cdb}, {31'b0, v});
    checkOutput({tag, "_tag"}, {28'b0, rob_id_to_cdb}, {28'b0, t});
    checkOutput({tag, "_data"}, result_to_cdb, d);
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    commit_jump_flag_from_rob = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step();
    rst = 1'b0;
    #1;
    checkBus("reset", 1'b0, 4'd0, 32'h0);
    checkOutput("reset_ready_alu", {31'b0, ready_to_alu}, 32'd1);
    checkOutput("reset_ready_lsb", {31'b0, ready_to_lsb}, 32'd1);

    // Single ALU request, tag 3.
    $display("[TB] single ALU request");
    applyStimulus(1'b1, 4'd3, 32'h0000_0010, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("single_ready_alu", {31'b0, ready_to_alu}, 32'd1);
    step();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
`ifdef CDB_ARB_BYPASS_EN
    checkBus("single_e1", 1'b1, 4'd3, 32'h0000_0010);
    step();
    checkOutput("single_e2_valid", {31'b0, valid_to_cdb}, 32'd0);
`else
    checkOutput("single_e1_valid", {31'b0, valid_to_cdb}, 32'd0);
    step();
    checkBus("single_e2", 1'b1, 4'd3, 32'h0000_0010);
    step();
    checkOutput("single_e3_valid", {31'b0, valid_to_cdb}, 32'd0);
`endif

    // Flush with both slots full; prio is 1 here from the ALU grant above.
    $display("[TB] flush mid-operation");
    applyStimulus(1'b1, 4'd4, 32'hA000_0004, 1'b1, 4'd9, 32'hB000_0009);
    step();
    checkOutput("flush_fill_valid", {31'b0, valid_to_cdb}, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd10, 32'hB000_000A);
    commit_jump_flag_from_rob = 1'b1;
    #1;
    checkOutput("flush_ready_lsb", {31'b0, ready_to_lsb}, 32'd1);
    checkOutput("flush_ready_alu", {31'b0, ready_to_alu}, 32'd0);
    step();
    commit_jump_flag_from_rob = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checkBus("flush_e0", 1'b0, 4'd0, 32'h0);
    for (int i = 1; i <= 2; i++) begin
      step();
      checkOutput($sformatf("flush_e%0d_valid", i), {31'b0, valid_to_cdb}, 32'd0);
    end

    // Contention: ALU first proves the flush restored prio to 0.
    $display("[TB] contention");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(c_av[i], c_at[i], 32'hA000_0000 | {28'b0, c_at[i]},
                    c_lv[i], c_lt[i], 32'hB000_0000 | {28'b0, c_lt[i]});
      #1;
      checkOutput($sformatf("cont%0d_ready_alu", i), {31'b0, ready_to_alu}, {31'b0, c_ra[i]});
      checkOutput($sformatf("cont%0d_ready_lsb", i), {31'b0, ready_to_lsb}, {31'b0, c_rl[i]});
      step();
      checkBus($sformatf("cont%0d", i), c_ev[i], c_et[i], c_ed[i]);
    end

    // rdy stall with the ALU slot holding tag 2.
    $display("[TB] rdy stall");
    applyStimulus(1'b1, 4'd2, 32'h0000_0222, 1'b0, 4'd0, 32'h0);
    step();
    checkOutput("stall_fill_valid", {31'b0, valid_to_cdb}, 32'd0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd11, 32'h0000_B00B);
    rdy = 1'b0;
    #1;
    checkOutput("stall_ready_alu", {31'b0, ready_to_alu}, 32'd0);
    checkOutput("stall_ready_lsb", {31'b0, ready_to_lsb}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("stall%0d_valid", i), {31'b0, valid_to_cdb}, 32'd0);
      checkOutput($sformatf("stall%0d_tag", i), {28'b0, rob_id_to_cdb}, 32'd7);
    end
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    rdy = 1'b1;
    #1;
    checkOutput("resume_ready_alu", {31'b0, ready_to_alu}, 32'd1);
    step();
    checkBus("resume", 1'b1, 4'd2, 32'h0000_0222);
    rdy = 1'b0;
    step();
    checkOutput("hold_valid", {31'b0, valid_to_cdb}, 32'd1);
    rdy = 1'b1;
    step();
    checkOutput("after_resume_valid", {31'b0, valid_to_cdb}, 32'd0);

    // Zero tag on the LSB is handshaken but dropped.
    $display("[TB] zero tag");
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd0, 32'hDEAD_BEEF);
    #1;
    checkOutput("zero_ready_lsb", {31'b0, ready_to_lsb}, 32'd1);
    step();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checkBus("zero_e1", 1'b0, 4'd2, 32'h0000_0222);
    step();
    checkBus("zero_e2", 1'b0, 4'd2, 32'h0000_0222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
